// File: rtl/mem_access_pkg.sv
`default_nettype none
// ============================================================================
// Module   : mem_access_pkg
// Brief    : Shared types, defaults and funct3 decoding for the data-RAM access unit
// Revision : 1.0
// ============================================================================
package mem_access_pkg;

  localparam logic [31:0] RAM_BASE_DEFAULT = 32'h0000_0000;
  localparam logic [31:0] RAM_TOP_DEFAULT  = 32'h0000_1FFF;

  typedef enum logic [2:0] {
    F3_LB  = 3'b000,
    F3_LH  = 3'b001,
    F3_LW  = 3'b010,
    F3_LBU = 3'b100,
    F3_LHU = 3'b101
  } load_funct3_e;

  typedef enum logic [2:0] {
    F3_SB = 3'b000,
    F3_SH = 3'b001,
    F3_SW = 3'b010
  } store_funct3_e;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_READ  = 2'd1,
    ST_WRITE = 2'd2,
    ST_RESP  = 2'd3
  } state_e;

  function automatic logic is_legal_funct3(input logic write, input logic [2:0] funct3);
    logic legal;
    if (write) begin
      legal = (funct3 == F3_SB) || (funct3 == F3_SH) || (funct3 == F3_SW);
    end else begin
      legal = (funct3 == F3_LB) || (funct3 == F3_LH) || (funct3 == F3_LW) ||
              (funct3 == F3_LBU) || (funct3 == F3_LHU);
    end
    return legal;
  endfunction

endpackage
`default_nettype wire

// File: rtl/mem_access_unit_load_extend.sv
`default_nettype none
// ============================================================================
// Module   : load_extend
// Brief    : Extracts the low byte/halfword/word of a RAM word and extends it
// Revision : 1.0
// ============================================================================
module load_extend
  import mem_access_pkg::*;
(
  input  logic [2:0]  i_funct3,
  input  logic [31:0] i_word,
  output logic [31:0] o_ext
);

  always_comb begin
    o_ext = i_word;
    case (i_funct3)
      F3_LB:   o_ext = {{24{i_word[7]}}, i_word[7:0]};
      F3_LBU:  o_ext = {24'h0, i_word[7:0]};
      F3_LH:   o_ext = {{16{i_word[15]}}, i_word[15:0]};
      F3_LHU:  o_ext = {16'h0, i_word[15:0]};
      default: o_ext = i_word;
    endcase
  end

endmodule
`default_nettype wire

// File: rtl/mem_access_unit.sv
`default_nettype none
// ============================================================================
// Module   : mem_access_unit
// Brief    : Load/store controller for a 4-byte-wide byte-addressed data RAM
// Revision : 1.0
// ============================================================================
module mem_access_unit
  import mem_access_pkg::*;
#(
  parameter int unsigned              ADDRESS_WIDTH = 32,
  parameter logic [ADDRESS_WIDTH-1:0] RAM_BASE      = RAM_BASE_DEFAULT,
  parameter logic [ADDRESS_WIDTH-1:0] RAM_TOP       = RAM_TOP_DEFAULT
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     req_valid,
  output logic                     req_ready,
  input  logic                     req_write,
  input  logic [2:0]               req_funct3,
  input  logic [ADDRESS_WIDTH-1:0] req_addr,
  input  logic [31:0]              req_wdata,
  output logic                     resp_valid,
  input  logic                     resp_ready,
  output logic [31:0]              resp_rdata,
  output logic                     resp_error,
  output logic                     mem_write_enable,
  output logic [ADDRESS_WIDTH-1:0] mem_address,
  output logic [31:0]              mem_wdata,
  input  logic [31:0]              mem_rdata
);

  state_e                   r_state;
  state_e                   w_state_next;
  logic                     r_write;
  logic [2:0]               r_funct3;
  logic [ADDRESS_WIDTH-1:0] r_addr;
  logic [31:0]              r_wdata;
  logic [31:8]              r_word_hi;
  logic [31:0]              r_rdata;
  logic                     r_error;

  logic [ADDRESS_WIDTH:0]   w_addr_end;
  logic                     w_in_range;
  logic                     w_req_error;
  logic [31:0]              w_load_ext;
  logic [31:0]              w_merged;

  // One extra bit so that an address near 2^W wraps out of range instead of back in.
  assign w_addr_end  = {1'b0, req_addr} + {{(ADDRESS_WIDTH-1){1'b0}}, 2'd3};
  assign w_in_range  = (req_addr >= RAM_BASE) && (w_addr_end <= {1'b0, RAM_TOP});
  assign w_req_error = !is_legal_funct3(req_write, req_funct3) || !w_in_range;

  load_extend u_load_extend (
    .i_funct3 (r_funct3),
    .i_word   (mem_rdata),
    .o_ext    (w_load_ext)
  );

  always_comb begin
    w_merged = r_wdata;
    case (r_funct3)
      F3_SB:   w_merged = {r_word_hi[31:8],  r_wdata[7:0]};
      F3_SH:   w_merged = {r_word_hi[31:16], r_wdata[15:0]};
      default: w_merged = r_wdata;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next     = r_state;
    req_ready        = 1'b0;
    resp_valid       = 1'b0;
    mem_write_enable = 1'b0;
    mem_wdata        = 32'h0;
    case (r_state)
      ST_IDLE: begin
        req_ready = 1'b1;
        if (req_valid) begin
          if (w_req_error) begin
            w_state_next = ST_RESP;
          end else if (req_write && (req_funct3 == F3_SW)) begin
            w_state_next = ST_WRITE;
          end else begin
            w_state_next = ST_READ;
          end
        end
      end
      ST_READ: begin
        w_state_next = r_write ? ST_WRITE : ST_RESP;
      end
      ST_WRITE: begin
        mem_write_enable = !rst;
        mem_wdata        = w_merged;
        w_state_next     = ST_RESP;
      end
      ST_RESP: begin
        resp_valid = 1'b1;
        if (resp_ready) begin
          w_state_next = ST_IDLE;
        end
      end
      default: w_state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_write   <= 1'b0;
      r_funct3  <= 3'b000;
      r_addr    <= '0;
      r_wdata   <= 32'h0;
      r_word_hi <= 24'h0;
      r_rdata   <= 32'h0;
      r_error   <= 1'b0;
    end else begin
      if ((r_state == ST_IDLE) && req_valid) begin
        r_write  <= req_write;
        r_funct3 <= req_funct3;
        r_addr   <= req_addr;
        r_wdata  <= req_wdata;
        r_rdata  <= 32'h0;
        r_error  <= w_req_error;
      end
      if (r_state == ST_READ) begin
        r_word_hi <= mem_rdata[31:8];
        if (!r_write) begin
          r_rdata <= w_load_ext;
        end
      end
    end
  end

  // Address stays on the latched request between accesses so the RAM never sees a glitch.
  assign mem_address = r_addr;
  assign resp_rdata  = r_rdata;
  assign resp_error  = r_error;

endmodule
`default_nettype wire

// File: tb/tb_mem_access_unit.sv
`default_nettype none
// ============================================================================
// Module   : tb_mem_access_unit
// Brief    : Directed plus randomized bench with a byte-level transaction model
// Revision : 1.0
// ============================================================================
module tb_mem_access_unit;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic        req_write = 1'b0;
  logic [2:0]  req_funct3 = 3'b000;
  logic [31:0] req_addr = 32'h0;
  logic [31:0] req_wdata = 32'h0;
  logic        resp_valid;
  logic        resp_ready = 1'b0;
  logic [31:0] resp_rdata;
  logic        resp_error;
  logic        mem_write_enable;
  logic [31:0] mem_address;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;

  mem_access_unit dut (
    .clk              (clk),
    .rst              (rst),
    .req_valid        (req_valid),
    .req_ready        (req_ready),
    .req_write        (req_write),
    .req_funct3       (req_funct3),
    .req_addr         (req_addr),
    .req_wdata        (req_wdata),
    .resp_valid       (resp_valid),
    .resp_ready       (resp_ready),
    .resp_rdata       (resp_rdata),
    .resp_error       (resp_error),
    .mem_write_enable (mem_write_enable),
    .mem_address      (mem_address),
    .mem_wdata        (mem_wdata),
    .mem_rdata        (mem_rdata)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got 0x%h required 0x%h", name, act, req);
    end
  endtask

  // RAM attached to the DUT, and the golden byte image the model keeps
  logic [7:0] ram  [0:8191];
  logic [7:0] gold [0:8191];

  always_comb begin
    mem_rdata = 32'h0;
    if (mem_address <= 32'h1FFC) begin
      mem_rdata = {ram[mem_address[12:0] + 13'd3], ram[mem_address[12:0] + 13'd2],
                   ram[mem_address[12:0] + 13'd1], ram[mem_address[12:0]]};
    end
  end

  always @(posedge clk) begin
    if (mem_write_enable && (mem_address <= 32'h1FFC)) begin
      for (int i = 0; i < 4; i++) ram[mem_address[12:0] + 13'(i)] <= mem_wdata[8*i +: 8];
    end
  end

  typedef struct {
    bit          w;
    bit          err;
    logic [31:0] addr;
    logic [31:0] rdata;
    logic [31:0] wdata;
    int          lat;
    int          nwr;
  } exp_t;

  function automatic exp_t predict(input bit w, input logic [2:0] f3,
                                   input logic [31:0] a, input logic [31:0] d);
    exp_t        e;
    logic [63:0] last;
    bit          ok_f3;
    int          n;
    logic [7:0]  b [4];
    logic [31:0] v;
    e.w = w; e.addr = a; e.rdata = 32'h0; e.wdata = 32'h0; e.nwr = 0; e.lat = 1;
    ok_f3 = w ? (f3 <= 3'd2) : ((f3 <= 3'd2) || (f3 == 3'd4) || (f3 == 3'd5));
    last  = {32'h0, a} + 64'd3;
    e.err = !ok_f3 || (last > 64'h1FFF);
    if (e.err) return e;
    n = (f3[1:0] == 2'd0) ? 1 : (f3[1:0] == 2'd1) ? 2 : 4;
    for (int i = 0; i < 4; i++) b[i] = gold[a[12:0] + 13'(i)];
    if (!w) begin
      v = 32'h0;
      for (int i = 0; i < n; i++) v[8*i +: 8] = b[i];
      if (!f3[2] && (n < 4) && b[n-1][7]) begin
        for (int i = n; i < 4; i++) v[8*i +: 8] = 8'hFF;
      end
      e.rdata = v;
      e.lat   = 2;
    end else begin
      for (int i = 0; i < n; i++) b[i] = d[8*i +: 8];
      e.wdata = {b[3], b[2], b[1], b[0]};
      e.nwr   = 1;
      e.lat   = (n == 4) ? 2 : 3;
    end
    return e;
  endfunction

  // Monitor: one transaction outstanding at a time
  exp_t        ex;
  bit          busy = 0;
  bit          seen = 0;
  int          cyc = 0;
  int          nwr = 0;
  int          last_lat = 0;
  int          last_nwr = 0;
  logic [31:0] last_wdata = 32'h0;

  always @(negedge clk) begin
    if (rst) begin
      busy = 0;
      chk("we_during_reset", 32'(mem_write_enable), 32'd0);
    end else if (busy) begin
      cyc++;
      chk("req_ready_busy", 32'(req_ready), 32'd0);
      if (mem_write_enable) begin
        nwr++;
        last_wdata = mem_wdata;
        chk("write_addr", mem_address, ex.addr);
        chk("write_data", mem_wdata, ex.wdata);
      end
      if (resp_valid) begin
        if (!seen) begin
          seen     = 1;
          last_lat = cyc;
          chk("latency", 32'(cyc), 32'(ex.lat));
        end
        chk("resp_rdata", resp_rdata, ex.rdata);
        chk("resp_error", 32'(resp_error), 32'(ex.err));
        if (resp_ready) begin
          last_nwr = nwr;
          chk("write_count", 32'(nwr), 32'(ex.nwr));
          if (ex.w && !ex.err) begin
            for (int i = 0; i < 4; i++) gold[ex.addr[12:0] + 13'(i)] = ex.wdata[8*i +: 8];
          end
          busy = 0;
        end
      end
    end else begin
      chk("idle_req_ready", 32'(req_ready), 32'd1);
      chk("idle_resp_valid", 32'(resp_valid), 32'd0);
      chk("idle_write_enable", 32'(mem_write_enable), 32'd0);
      if (req_valid) begin
        ex   = predict(req_write, req_funct3, req_addr, req_wdata);
        busy = 1; seen = 0; cyc = 0; nwr = 0;
      end
    end
  end

  task automatic preload(input logic [31:0] a, input logic [31:0] word);
    for (int i = 0; i < 4; i++) begin
      ram[a[12:0] + 13'(i)]  = word[8*i +: 8];
      gold[a[12:0] + 13'(i)] = word[8*i +: 8];
    end
  endtask

  task automatic drive(input bit w, input logic [2:0] f3, input logic [31:0] a, input logic [31:0] d);
    req_write = w; req_funct3 = f3; req_addr = a; req_wdata = d; req_valid = 1'b1;
  endtask

  task automatic wait_accept();
    bit got = 0;
    for (int n = 0; n < 50; n++) begin
      @(negedge clk);
      if (req_ready) begin got = 1; break; end
    end
    chk("accept_seen", 32'(got), 32'd1);
    @(posedge clk); #1;
  endtask

  task automatic finish_resp(input int hold, output logic [31:0] rd, output logic er);
    bit got = 0;
    for (int n = 0; n < 50; n++) begin
      @(negedge clk);
      if (resp_valid) begin got = 1; break; end
    end
    chk("resp_seen", 32'(got), 32'd1);
    rd = resp_rdata;
    er = resp_error;
    repeat (hold) @(posedge clk);
    @(posedge clk); #1 resp_ready = 1'b1;
    @(posedge clk); #1 resp_ready = 1'b0;
  endtask

  task automatic do_req(input bit w, input logic [2:0] f3, input logic [31:0] a,
                        input logic [31:0] d, input int hold,
                        output logic [31:0] rd, output logic er);
    drive(w, f3, a, d);
    wait_accept();
    req_valid = 1'b0;
    finish_resp(hold, rd, er);
  endtask

  initial begin
    logic [31:0] rd, rd2;
    logic        er, er2;
    int          diffs;
    logic [31:0] a;
    for (int i = 0; i < 8192; i++) begin
      ram[i]  = 8'(i * 7 + 3);
      gold[i] = 8'(i * 7 + 3);
    end
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_req_ready", 32'(req_ready), 32'd1);
    chk("rst_resp_valid", 32'(resp_valid), 32'd0);
    chk("rst_resp_error", 32'(resp_error), 32'd0);
    chk("rst_resp_rdata", resp_rdata, 32'h0);
    chk("rst_mem_address", mem_address, 32'h0);
    chk("rst_mem_wdata", mem_wdata, 32'h0);
    @(posedge clk); #1 rst = 1'b0;

    // load extension
    preload(32'h1000, 32'h1234_7F80);
    do_req(0, 3'b000, 32'h1000, 0, 0, rd, er);
    chk("lb_data", rd, 32'hFFFF_FF80); chk("lb_err", 32'(er), 0); chk("lb_lat", 32'(last_lat), 2);
    do_req(0, 3'b100, 32'h1000, 0, 1, rd, er);
    chk("lbu_data", rd, 32'h0000_0080); chk("lbu_lat", 32'(last_lat), 2);
    do_req(0, 3'b001, 32'h1000, 0, 0, rd, er);
    chk("lh_data", rd, 32'h0000_7F80); chk("lh_lat", 32'(last_lat), 2);
    do_req(0, 3'b010, 32'h1000, 0, 0, rd, er);
    chk("lw_data", rd, 32'h1234_7F80); chk("lw_err", 32'(er), 0);

    // byte read-modify-write
    preload(32'h1000, 32'h1122_3344);
    do_req(1, 3'b000, 32'h1000, 32'hAAAA_AAEE, 0, rd, er);
    chk("sb_wdata", last_wdata, 32'h1122_33EE); chk("sb_writes", 32'(last_nwr), 1);
    chk("sb_lat", 32'(last_lat), 3); chk("sb_rdata", rd, 32'h0);
    do_req(0, 3'b010, 32'h1000, 0, 0, rd, er);
    chk("sb_readback", rd, 32'h1122_33EE);

    // word store and halfword merges
    do_req(1, 3'b010, 32'h1010, 32'hDEAD_BEEF, 0, rd, er);
    chk("sw_lat", 32'(last_lat), 2); chk("sw_writes", 32'(last_nwr), 1);
    do_req(1, 3'b001, 32'h1010, 32'h0000_BEEF, 0, rd, er);
    do_req(0, 3'b010, 32'h1010, 0, 0, rd, er);
    chk("sh_same_readback", rd, 32'hDEAD_BEEF);
    do_req(1, 3'b001, 32'h1010, 32'h0000_1234, 0, rd, er);
    do_req(0, 3'b010, 32'h1010, 0, 0, rd, er);
    chk("sh_readback", rd, 32'hDEAD_1234);

    // errors
    do_req(0, 3'b010, 32'h1FFD, 0, 0, rd, er);
    chk("err_top_flag", 32'(er), 1); chk("err_top_lat", 32'(last_lat), 1); chk("err_top_writes", 32'(last_nwr), 0);
    do_req(1, 3'b100, 32'h1000, 32'h5555_5555, 0, rd, er);
    chk("err_f3_flag", 32'(er), 1); chk("err_f3_lat", 32'(last_lat), 1); chk("err_f3_writes", 32'(last_nwr), 0);
    do_req(0, 3'b010, 32'hFFFF_FFFE, 0, 0, rd, er);
    chk("err_wrap_flag", 32'(er), 1); chk("err_wrap_rdata", rd, 32'h0); chk("err_wrap_lat", 32'(last_lat), 1);

    // backpressure with a second request held pending
    drive(0, 3'b010, 32'h1000, 0);
    wait_accept();
    drive(0, 3'b100, 32'h1001, 0);
    finish_resp(5, rd, er);
    wait_accept();
    req_valid = 1'b0;
    finish_resp(0, rd2, er2);
    chk("bp_first", rd, 32'h1122_33EE); chk("bp_second", rd2, 32'h0000_0033);

    // reset during the write cycle of a byte store
    drive(1, 3'b000, 32'h1000, 32'h0000_0055);
    wait_accept();
    req_valid = 1'b0;
    @(posedge clk); #1 rst = 1'b1;
    @(negedge clk);
    chk("rst_write_suppressed", 32'(mem_write_enable), 32'd0);
    @(posedge clk); #1 rst = 1'b0;
    @(negedge clk);
    chk("post_rst_ready", 32'(req_ready), 32'd1);
    chk("post_rst_valid", 32'(resp_valid), 32'd0);
    @(posedge clk); #1;
    do_req(0, 3'b010, 32'h1000, 0, 0, rd, er);
    chk("post_rst_readback", rd, 32'h1122_33EE);

    // randomized traffic against the model
    for (int t = 0; t < 300; t++) begin
      case ($urandom_range(0, 9))
        0, 1, 2, 3, 4, 5, 6: a = 32'h1000 + 32'($urandom_range(0, 63));
        7:       a = 32'h1FF8 + 32'($urandom_range(0, 7));
        8:       a = 32'hFFFF_FFF0 + 32'($urandom_range(0, 15));
        default: a = $urandom;
      endcase
      do_req(1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)), a, $urandom,
             $urandom_range(0, 2), rd, er);
    end

    diffs = 0;
    for (int i = 0; i < 8192; i++) if (ram[i] !== gold[i]) diffs++;
    chk("ram_image", 32'(diffs), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/mem_access_unit.md
Name: mem_access_unit

Overview:
- Initiator-side controller for the byte-addressed data RAM.
- Accepts load/store requests from the datapath over a valid/ready handshake and drives the RAM's address, write-enable and 32-bit write-data lines.
- The RAM always reads and writes 4 bytes at address..address+3. This block therefore:
  - performs read-modify-write for byte and halfword stores;
  - sign- or zero-extends load data;
  - range-checks addresses.
- Returns one response per request.

Parameters:
- ADDRESS_WIDTH, 32, width of request and RAM address.
- RAM_BASE, 32'h00000000, lowest legal byte address.
- RAM_TOP, 32'h00001FFF, highest legal byte address. The access is legal iff RAM_BASE <= addr and addr+3 <= RAM_TOP.

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous active-high reset.
- req_valid  in  1  request present.
- req_ready  out  1  unit can accept a request.
- req_write  in  1  1=store, 0=load.
- req_funct3  in  3  RISC-V funct3 access size/sign.
- req_addr  in  ADDRESS_WIDTH  byte address.
- req_wdata  in  32  store data, low-aligned.
- resp_valid  out  1  response present.
- resp_ready  in  1  consumer takes response.
- resp_rdata  out  32  extended load data; 0 for stores and errors.
- resp_error  out  1  illegal funct3 or out-of-range address.
- mem_write_enable  out  1  to RAM write_enable.
- mem_address  out  ADDRESS_WIDTH  to RAM address.
- mem_wdata  out  32  to RAM ramin.
- mem_rdata  in  32  from RAM ramout (combinational read).

Behaviour:
- Reset values:
  - state = IDLE; req_ready = 1; resp_valid = 0; resp_error = 0.
  - resp_rdata, mem_address and mem_wdata = 0.
  - mem_write_enable = 0.
- FSM states: IDLE, READ, WRITE, RESP.
- IDLE:
  - req_ready = 1.
  - On req_valid, latch write, funct3, addr and wdata, then decode.
  - Error conditions: illegal funct3, or range fail. Loads allow 000, 001, 010, 100, 101; stores allow 000, 001, 010. On error go to RESP with resp_error = 1; no RAM access.
  - Otherwise: load → READ; SW → WRITE; SB/SH → READ.
- READ (1 cycle):
  - mem_address = latched addr; capture mem_rdata into a word register.
  - Load: extract and extend into the response register, then go to RESP.
    - LB: sign-extend [7:0]. LBU: zero-extend [7:0].
    - LH: sign-extend [15:0]. LHU: zero-extend [15:0].
    - LW: pass all 32 bits.
  - SB/SH: go to WRITE.
- WRITE (1 cycle):
  - mem_address = latched addr; mem_write_enable = 1.
  - mem_wdata:
    - SW: wdata.
    - SH: {captured[31:16], wdata[15:0]}.
    - SB: {captured[31:8], wdata[7:0]}.
  - Next state RESP.
- RESP:
  - resp_valid = 1; req_ready = 0.
  - Outputs are held stable until resp_ready. On resp_valid & resp_ready, go to IDLE.
  - A new request can be accepted no earlier than the cycle after the handshake.
- Latency (accept edge to resp_valid):
  - load: 2 cycles;
  - SW: 2 cycles;
  - SB/SH: 3 cycles;
  - error: 1 cycle.
- mem_write_enable is asserted only in WRITE and only for exactly one cycle per store. It is gated with !rst: reset asserted during WRITE suppresses the write.
- mem_address holds the latched address outside READ/WRITE, so the RAM sees no spurious write.
- Range check: compute addr+3 in ADDRESS_WIDTH+1 bits. A wrap past 2^32 is out of range.
- Reset mid-operation: on any state, at the rst edge, return to IDLE. The latched request is discarded and no response is issued.
- req_valid while not in IDLE is ignored. It is not a protocol error, since req_ready is low.

Decomposition:
- Package mem_access_pkg:
  - typedef enum for funct3 codes (LB, LH, LW, LBU, LHU; SB, SH, SW);
  - FSM state enum;
  - RAM_BASE/RAM_TOP defaults;
  - function is_legal_funct3(write, funct3).
- One sub-module: load_extend. Combinational; takes funct3 and a 32-bit word and returns the extended 32-bit value. Instantiated once in READ-path logic.

Test Plan:
- Load extension: preload RAM[0x1000..0x1003] = 80 7F 34 12, then issue four loads at 0x1000:
  - LB → 0xFFFFFF80;
  - LBU → 0x00000080;
  - LH → 0x00007F80;
  - LW → 0x12347F80.
  - Each load gives resp_valid 2 cycles after accept and resp_error = 0.
- SB read-modify-write: RAM[0x1000..0x1003] = 44 33 22 11; SB addr 0x1000, wdata 0xAAAAAAEE. Required: exactly one write cycle with mem_wdata = 0x112233EE; a subsequent LW returns 0x112233EE.
- SW: addr 0x1010, wdata 0xDEADBEEF. Required: no READ cycle, write-enable for one cycle, response 2 cycles after accept. SH 0xBEEF then LW of the same location is unchanged; SH 0x1234 at 0x1010 gives LW = 0xDEAD1234.
- Errors, each giving resp_error = 1 at latency 1 with write-enable never asserted:
  - LW at 0x1FFD (addr+3 = 0x2000);
  - store with funct3 = 3'b100;
  - LW at 0xFFFFFFFE (wrap).
- Backpressure: hold resp_ready = 0 for 5 cycles after an LW. Required: resp_valid and resp_rdata stable, req_ready = 0, a second req_valid ignored; the request is accepted only after the handshake.
- Reset mid-op: assert rst during the WRITE cycle of an SB. Required: mem_write_enable = 0 in that cycle, RAM unchanged, state IDLE, resp_valid = 0, req_ready = 1 the next cycle.
